// File: rtl/bus_ctrl_pkg.sv
// Shared types and status-code constants for the 8288-style bus controller.
// Command types are one-hot vectors indexed by their 3-bit status code.
package bus_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4
    } bus_state_e;

    localparam logic [2:0] STS_INTA    = 3'b000;
    localparam logic [2:0] STS_IOR     = 3'b001;
    localparam logic [2:0] STS_IOW     = 3'b010;
    localparam logic [2:0] STS_HALT    = 3'b011;
    localparam logic [2:0] STS_FETCH   = 3'b100;
    localparam logic [2:0] STS_MEMR    = 3'b101;
    localparam logic [2:0] STS_MEMW    = 3'b110;
    localparam logic [2:0] STS_PASSIVE = 3'b111;

    localparam int CMD_W = 8;
    typedef logic [CMD_W-1:0] cmd_onehot_t;

    function automatic cmd_onehot_t onehot_of(input logic [2:0] sts);
        cmd_onehot_t v;
        v = '0;
        v[sts] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/bus_status_decode.sv
// Combinational decode of the active-low CPU status into a one-hot command type.
import bus_ctrl_pkg::*;

module bus_status_decode (
    input  logic [2:0] s_n,
    output logic [7:0] cmd_type
);

    always_comb begin
        cmd_type = '0;
        case (s_n)
            STS_INTA:  cmd_type = onehot_of(STS_INTA);
            STS_IOR:   cmd_type = onehot_of(STS_IOR);
            STS_IOW:   cmd_type = onehot_of(STS_IOW);
            STS_HALT:  cmd_type = onehot_of(STS_HALT);
            STS_FETCH: cmd_type = onehot_of(STS_FETCH);
            STS_MEMR:  cmd_type = onehot_of(STS_MEMR);
            STS_MEMW:  cmd_type = onehot_of(STS_MEMW);
            default:   cmd_type = onehot_of(STS_PASSIVE);
        endcase
    end

endmodule

// File: rtl/bus_ctrl_8288.sv
// 8288-style bus controller: T-state sequencer, command register and output gating.
// Optional BUS_CTRL_ADV_WRITE_EN enables the advanced write strobes amwc_n/aiowc_n.
import bus_ctrl_pkg::*;

module bus_ctrl_8288 (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] s_n,
    input  logic       aen_n,
    input  logic       cen,
    output logic       ale,
    output logic       den,
    output logic       dt_r_n,
    output logic       mrdc_n,
    output logic       mwtc_n,
    output logic       iorc_n,
    output logic       iowc_n,
    output logic       inta_n,
    output logic       amwc_n,
    output logic       aiowc_n,
    output logic [2:0] state_dbg
);

    bus_state_e  state_q, state_d;
    cmd_onehot_t cmd_q, cmd_d;
    cmd_onehot_t type_now;
    logic        passive;

    bus_status_decode u_decode (
        .s_n      (s_n),
        .cmd_type (type_now)
    );

    assign passive   = type_now[STS_PASSIVE];
    assign state_dbg = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
        end
    end

    // The command type is latched only when a new bus cycle starts (T1 entry).
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        case (state_q)
            ST_IDLE: begin
                if (!passive) begin
                    state_d = ST_T1;
                    cmd_d   = type_now;
                end
            end
            ST_T1:   state_d = passive ? ST_T4 : ST_T2;
            ST_T2:   state_d = passive ? ST_T4 : ST_T3;
            ST_T3:   state_d = passive ? ST_T4 : ST_T3;
            ST_T4: begin
                if (passive) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_T1;
                    cmd_d   = type_now;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic in_cmd;
    logic in_t3;
    logic is_read;
    logic cmd_ok;

    always_comb begin
        in_cmd  = (state_q == ST_T2) || (state_q == ST_T3);
        in_t3   = (state_q == ST_T3);
        is_read = cmd_q[STS_INTA] | cmd_q[STS_IOR] | cmd_q[STS_FETCH] | cmd_q[STS_MEMR];
        // aen_n and cen act directly on the strobes, independent of the sequencer.
        cmd_ok  = cen & ~aen_n;

        ale     = (state_q == ST_T1);
        dt_r_n  = (state_q == ST_IDLE) ? 1'b1 : ~is_read;
        den     = in_cmd & cen & ~(cmd_q[STS_HALT] | cmd_q[STS_PASSIVE]);

        mrdc_n  = ~(in_cmd & cmd_ok & (cmd_q[STS_FETCH] | cmd_q[STS_MEMR]));
        iorc_n  = ~(in_cmd & cmd_ok & cmd_q[STS_IOR]);
        inta_n  = ~(in_cmd & cmd_ok & cmd_q[STS_INTA]);
        mwtc_n  = ~(in_t3 & cmd_ok & cmd_q[STS_MEMW]);
        iowc_n  = ~(in_t3 & cmd_ok & cmd_q[STS_IOW]);
`ifdef BUS_CTRL_ADV_WRITE_EN
        amwc_n  = ~(in_cmd & cmd_ok & cmd_q[STS_MEMW]);
        aiowc_n = ~(in_cmd & cmd_ok & cmd_q[STS_IOW]);
`else
        amwc_n  = 1'b1;
        aiowc_n = 1'b1;
`endif
    end

endmodule

// File: tb/tb_bus_ctrl_8288.sv
// Self-checking bench for bus_ctrl_8288: directed vector table, reset corner case,
// and randomized status traffic checked against a phase-counting reference model.
module tb_bus_ctrl_8288;

`ifdef BUS_CTRL_ADV_WRITE_EN
    localparam logic ADV = 1'b1;
`else
    localparam logic ADV = 1'b0;
`endif

    // Low-mask bit positions within the 7 command bits of the packed output vector.
    localparam logic [6:0] L_MRDC  = 7'b1000000;
    localparam logic [6:0] L_MWTC  = 7'b0100000;
    localparam logic [6:0] L_IORC  = 7'b0010000;
    localparam logic [6:0] L_IOWC  = 7'b0001000;
    localparam logic [6:0] L_AMWC  = ADV ? 7'b0000010 : 7'b0000000;
    localparam logic [6:0] L_AIOWC = ADV ? 7'b0000001 : 7'b0000000;
    localparam int         P_END   = -1;

    logic       clk;
    logic       reset;
    logic [2:0] s_n;
    logic       aen_n;
    logic       cen;
    logic       ale, den, dt_r_n;
    logic       mrdc_n, mwtc_n, iorc_n, iowc_n, inta_n, amwc_n, aiowc_n;
    logic [2:0] state_dbg;

    bus_ctrl_8288 dut (
        .clk       (clk),
        .reset     (reset),
        .s_n       (s_n),
        .aen_n     (aen_n),
        .cen       (cen),
        .ale       (ale),
        .den       (den),
        .dt_r_n    (dt_r_n),
        .mrdc_n    (mrdc_n),
        .mwtc_n    (mwtc_n),
        .iorc_n    (iorc_n),
        .iowc_n    (iowc_n),
        .inta_n    (inta_n),
        .amwc_n    (amwc_n),
        .aiowc_n   (aiowc_n),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking infrastructure ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [9:0] exp_q[$];

    typedef struct {
        logic [2:0] s;
        logic       a;
        logic       c;
        logic [9:0] exp;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [9:0] ev(input logic a, input logic d, input logic t,
                                      input logic [6:0] low);
        return {a, d, t, ~low};
    endfunction

    function automatic logic [9:0] dut_vec();
        return {ale, den, dt_r_n, mrdc_n, mwtc_n, iorc_n, iowc_n, inta_n, amwc_n, aiowc_n};
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (ale,den,dtr,mrdc,mwtc,iorc,iowc,inta,amwc,aiowc)",
                     name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 = no bus cycle, 1 = address phase, 2.. = clocks into the cycle, P_END = closing clock.
    int         m_phase = 0;
    logic [2:0] m_kind  = 3'b111;

    task automatic model_step(input logic [2:0] s, input logic r);
        if (r) begin
            m_phase = 0;
        end else if (m_phase == 0 || m_phase == P_END) begin
            if (s != 3'b111) begin
                m_phase = 1;
                m_kind  = s;
            end else begin
                m_phase = 0;
            end
        end else if (s == 3'b111) begin
            m_phase = P_END;
        end else if (m_phase < 1000) begin
            m_phase = m_phase + 1;
        end
    endtask

    function automatic logic [9:0] model_out(input logic a, input logic c);
        logic active, rd, ok;
        logic [6:0] low;
        active = (m_phase >= 2);
        rd     = (m_kind == 3'b000) || (m_kind == 3'b001) || (m_kind == 3'b100) || (m_kind == 3'b101);
        ok     = c && !a;
        low    = '0;
        if (active && ok) begin
            case (m_kind)
                3'b000: low = 7'b0000100;
                3'b001: low = L_IORC;
                3'b010: low = L_AIOWC | ((m_phase >= 3) ? L_IOWC : 7'b0);
                3'b100, 3'b101: low = L_MRDC;
                3'b110: low = L_AMWC | ((m_phase >= 3) ? L_MWTC : 7'b0);
                default: low = '0;
            endcase
        end
        return ev(m_phase == 1,
                  active && c && (m_kind != 3'b011),
                  (m_phase == 0) ? 1'b1 : !rd,
                  low);
    endfunction

    // ---------------- driver ----------------
    task automatic cycle(input logic [2:0] s, input logic a, input logic c, input logic r);
        logic [9:0] e;
        logic [4:0] cmds;
        @(negedge clk);
        s_n   = s;
        aen_n = a;
        cen   = c;
        reset = r;
        @(posedge clk);
        model_step(s, r);
        exp_q.push_back(model_out(a, c));
        #1;
        e = exp_q.pop_front();
        check("scoreboard", dut_vec(), e);
        cmds = {mrdc_n, mwtc_n, iorc_n, iowc_n, inta_n};
        n_checks++;
        if ($countones(~cmds) > 1) begin
            n_errors++;
            $display("FAIL one_cmd: got commands %b expected at most one low", cmds);
        end
    endtask

    task automatic add(input logic [2:0] s, input logic a, input logic c, input logic [9:0] exp);
        vec_t v;
        v.s = s; v.a = a; v.c = c; v.exp = exp;
        vecs.push_back(v);
    endtask

    // ---------------- test ----------------
    initial begin
        reset = 1'b1;
        s_n   = 3'b111;
        aen_n = 1'b0;
        cen   = 1'b1;
        #1;
        check("reset_values", dut_vec(), ev(0, 0, 1, 7'b0));

        // MEMR, 3 clocks active then passive
        add(3'b101, 0, 1, ev(1, 0, 0, 7'b0));
        add(3'b101, 0, 1, ev(0, 1, 0, L_MRDC));
        add(3'b101, 0, 1, ev(0, 1, 0, L_MRDC));
        add(3'b111, 0, 1, ev(0, 0, 0, 7'b0));
        add(3'b111, 0, 1, ev(0, 0, 1, 7'b0));
        // back-to-back MEMR, second cycle aborted in T1
        add(3'b101, 0, 1, ev(1, 0, 0, 7'b0));
        add(3'b101, 0, 1, ev(0, 1, 0, L_MRDC));
        add(3'b101, 0, 1, ev(0, 1, 0, L_MRDC));
        add(3'b101, 0, 1, ev(0, 1, 0, L_MRDC));
        add(3'b111, 0, 1, ev(0, 0, 0, 7'b0));
        add(3'b101, 0, 1, ev(1, 0, 0, 7'b0));
        add(3'b111, 0, 1, ev(0, 0, 0, 7'b0));
        add(3'b111, 0, 1, ev(0, 0, 1, 7'b0));
        // IOW with two wait states
        add(3'b010, 0, 1, ev(1, 0, 1, 7'b0));
        add(3'b010, 0, 1, ev(0, 1, 1, L_AIOWC));
        add(3'b010, 0, 1, ev(0, 1, 1, L_IOWC | L_AIOWC));
        add(3'b010, 0, 1, ev(0, 1, 1, L_IOWC | L_AIOWC));
        add(3'b010, 0, 1, ev(0, 1, 1, L_IOWC | L_AIOWC));
        add(3'b111, 0, 1, ev(0, 0, 1, 7'b0));
        add(3'b111, 0, 1, ev(0, 0, 1, 7'b0));
        // HALT
        add(3'b011, 0, 1, ev(1, 0, 1, 7'b0));
        add(3'b011, 0, 1, ev(0, 0, 1, 7'b0));
        add(3'b011, 0, 1, ev(0, 0, 1, 7'b0));
        add(3'b111, 0, 1, ev(0, 0, 1, 7'b0));
        add(3'b111, 0, 1, ev(0, 0, 1, 7'b0));
        // MEMW ungated
        add(3'b110, 0, 1, ev(1, 0, 1, 7'b0));
        add(3'b110, 0, 1, ev(0, 1, 1, L_AMWC));
        add(3'b110, 0, 1, ev(0, 1, 1, L_MWTC | L_AMWC));
        add(3'b111, 0, 1, ev(0, 0, 1, 7'b0));
        add(3'b111, 0, 1, ev(0, 0, 1, 7'b0));
        // MEMW with aen_n high
        add(3'b110, 1, 1, ev(1, 0, 1, 7'b0));
        add(3'b110, 1, 1, ev(0, 1, 1, 7'b0));
        add(3'b110, 1, 1, ev(0, 1, 1, 7'b0));
        add(3'b111, 1, 1, ev(0, 0, 1, 7'b0));
        add(3'b111, 0, 1, ev(0, 0, 1, 7'b0));
        // MEMW with cen low
        add(3'b110, 0, 0, ev(1, 0, 1, 7'b0));
        add(3'b110, 0, 0, ev(0, 0, 1, 7'b0));
        add(3'b110, 0, 0, ev(0, 0, 1, 7'b0));
        add(3'b111, 0, 1, ev(0, 0, 1, 7'b0));
        add(3'b111, 0, 1, ev(0, 0, 1, 7'b0));

        cycle(3'b111, 0, 1, 1);
        cycle(3'b111, 0, 1, 1);
        cycle(3'b111, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].s, vecs[i].a, vecs[i].c, 1'b0);
            check($sformatf("vec%0d", i), dut_vec(), vecs[i].exp);
        end

        // Reset asserted asynchronously in T3 of a MEMR
        cycle(3'b101, 0, 1, 0);
        cycle(3'b101, 0, 1, 0);
        cycle(3'b101, 0, 1, 0);
        check("pre_reset_t3", dut_vec(), ev(0, 1, 0, L_MRDC));
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_step(3'b101, 1'b1);
        check("async_reset", dut_vec(), ev(0, 0, 1, 7'b0));
        cycle(3'b101, 0, 1, 1);
        check("held_reset", dut_vec(), ev(0, 0, 1, 7'b0));
        cycle(3'b101, 0, 1, 1);
        cycle(3'b101, 0, 1, 0);
        check("post_release_t1", dut_vec(), ev(1, 0, 0, 7'b0));
        cycle(3'b111, 0, 1, 0);
        cycle(3'b111, 0, 1, 0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            logic [2:0] s;
            logic a, c, r;
            s = ($urandom_range(0, 99) < 35) ? 3'b111 : 3'($urandom_range(0, 6));
            a = ($urandom_range(0, 9) == 0);
            c = ($urandom_range(0, 9) != 0);
            r = ($urandom_range(0, 99) == 0);
            cycle(s, a, c, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
